// File: rtl/load_store_unit_if.sv
// Request/response channel between the memory-stage control and the load/store unit.
// The master side issues requests; the slave side (the unit) answers with a one-cycle response.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_error;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-wide DataMemory.
// Sub-word stores are read-modify-write; misaligned or illegal-size requests trap without touching memory.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  load_store_unit_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  MemWriteEnable,
  output logic                  MemReadEnable,
  input  logic [DATA_WIDTH-1:0] MemReadData
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdword_q;
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_error_q;

  function automatic logic access_error(input logic [1:0] sz, input logic [1:0] a);
    logic e;
    case (sz)
      SZ_BYTE: e = 1'b0;
      SZ_HALF: e = a[0];
      SZ_WORD: e = (a != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Replace only the addressed little-endian lane(s) of the old word.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_w, input logic [31:0] wd,
                                             input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] r;
    r = old_w;
    case (sz)
      SZ_BYTE: begin
        case (a)
          2'b00:   r[7:0]   = wd[7:0];
          2'b01:   r[15:8]  = wd[7:0];
          2'b10:   r[23:16] = wd[7:0];
          2'b11:   r[31:24] = wd[7:0];
          default: r        = old_w;
        endcase
      end
      SZ_HALF: begin
        if (a[1]) begin
          r[31:16] = wd[15:0];
        end else begin
          r[15:0] = wd[15:0];
        end
      end
      SZ_WORD: r = wd;
      default: r = old_w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract_lane(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sg, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      2'b11:   b = w[31:24];
      default: b = 8'h00;
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: r = {{24{sg & b[7]}}, b};
      SZ_HALF: r = {{16{sg & h[15]}}, h};
      SZ_WORD: r = w;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Control FSM, request latch and registered response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      rdword_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          resp_valid_q <= 1'b0;
          if (bus.req_valid) begin
            addr_q   <= bus.req_addr;
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            write_q  <= bus.req_write;
            wdata_q  <= bus.req_wdata;
            if (access_error(bus.req_size, bus.req_addr[1:0])) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= '0;
            end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
              state_q <= ST_WRITE;
            end else begin
              // Loads and sub-word stores both start by reading the word.
              state_q <= ST_READ;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (write_q) begin
            rdword_q <= MemReadData;
            state_q  <= ST_WRITE;
          end else begin
            resp_rdata_q <= extract_lane(MemReadData, size_q, signed_q, addr_q[1:0]);
            resp_error_q <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_WRITE: begin
          resp_rdata_q <= '0;
          resp_error_q <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_error = resp_error_q;

  // Memory-side strobes; gating with reset keeps a write from committing on the reset edge.
  always_comb begin
    MemAddr        = '0;
    MemWriteData   = '0;
    MemWriteEnable = 1'b0;
    MemReadEnable  = 1'b0;
    case (state_q)
      ST_READ: begin
        MemAddr       = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        MemReadEnable = reset;
      end
      ST_WRITE: begin
        MemAddr        = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        MemWriteData   = merge_lane(rdword_q, wdata_q, size_q, addr_q[1:0]);
        MemWriteEnable = reset;
      end
      default: begin
        MemAddr = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural DataMemory.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic        MemWriteEnable;
  logic        MemReadEnable;
  logic [31:0] MemReadData;

  logic [31:0] mem [0:15];
  logic        mem_clear;
  int          wr_count;
  int          rd_count;
  logic [31:0] last_waddr;

  int errors;
  int checks;

  load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .MemAddr        (MemAddr),
    .MemWriteData   (MemWriteData),
    .MemWriteEnable (MemWriteEnable),
    .MemReadEnable  (MemReadEnable),
    .MemReadData    (MemReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign MemReadData = mem[MemAddr[5:2]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      wr_count <= 0;
      rd_count <= 0;
      last_waddr <= 32'h0;
    end else begin
      if (MemWriteEnable) begin
        mem[MemAddr[5:2]] <= MemWriteData;
        wr_count <= wr_count + 1;
        last_waddr <= MemAddr;
      end
      if (MemReadEnable) rd_count <= rd_count + 1;
    end
  end

  // Issue one request from IDLE, return latency (edges from accept to resp_valid) and response.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.resp_valid !== 1'b1) lat = -1;
    rd = bus.resp_rdata;
    er = bus.resp_error;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_clear = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid); end
    checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got=%h want=0", bus.resp_rdata); end
    checks++; if (bus.resp_error !== 1'b0) begin errors++; $display("FAIL reset_resp_error got=%b want=0", bus.resp_error); end
    checks++; if (MemWriteEnable !== 1'b0 || MemReadEnable !== 1'b0) begin errors++; $display("FAIL reset_mem_en got=%b%b want=00", MemWriteEnable, MemReadEnable); end
    reset = 1'b1; mem_clear = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", bus.req_ready); end
    checks++; if (MemAddr !== 32'h0) begin errors++; $display("FAIL reset_memaddr got=%h want=0", MemAddr); end
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic er; int w0;
    w0 = wr_count;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got=%0d want=2", lat); end
    checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL sw_write_pulses got=%0d want=1", wr_count - w0); end
    checks++; if (last_waddr !== 32'h10) begin errors++; $display("FAIL sw_memaddr got=%h want=00000010", last_waddr); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem got=%h want=deadbeef", mem[4]); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_resp got=%h/%b want=0/0", rd, er); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got=%0d want=2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got=%h want=deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_error got=%b want=0", er); end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic er; int w0; int r0;
    w0 = wr_count; r0 = rd_count;
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AA, lat, rd, er);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency got=%0d want=3", lat); end
    checks++; if (rd_count - r0 !== 1 || wr_count - w0 !== 1) begin errors++; $display("FAIL sb_pulses got=r%0d/w%0d want=r1/w1", rd_count - r0, wr_count - w0); end
    checks++; if (mem[4] !== 32'hAAADBEEF) begin errors++; $display("FAIL sb_mem got=%h want=aaadbeef", mem[4]); end
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_signed got=%h want=ffffffaa", rd); end
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL lbu got=%h want=000000aa", rd); end
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h000000BE) begin errors++; $display("FAIL lbu_lane1 got=%h want=000000be", rd); end
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, lat, rd, er);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sh_latency got=%0d want=3", lat); end
    checks++; if (mem[4] !== 32'h1234BEEF) begin errors++; $display("FAIL sh_mem got=%h want=1234beef", mem[4]); end
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_signed got=%h want=ffffbeef", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL lhu got=%h want=00001234", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er; int w0; int r0;
    w0 = wr_count; r0 = rd_count;
    do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, lat, rd, er);
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_lw_misaligned got=lat%0d/%b/%h want=lat1/1/0", lat, er, rd); end
    do_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000FFFF, lat, rd, er);
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_sh_misaligned got=lat%0d/%b/%h want=lat1/1/0", lat, er, rd); end
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, er);
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_size11 got=lat%0d/%b/%h want=lat1/1/0", lat, er, rd); end
    checks++; if (wr_count != w0 || rd_count != r0) begin errors++; $display("FAIL err_no_mem_access got=r%0d/w%0d want=r0/w0", rd_count - r0, wr_count - w0); end
    checks++; if (mem[4] !== 32'h1234BEEF) begin errors++; $display("FAIL err_mem_kept got=%h want=1234beef", mem[4]); end
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = wr_count;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h00000055;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++; if (MemReadEnable !== 1'b1) begin errors++; $display("FAIL rst_mid_read got=%b want=1", MemReadEnable); end
    @(posedge clk); #1;
    checks++; if (MemWriteEnable !== 1'b1) begin errors++; $display("FAIL rst_mid_in_write got=%b want=1", MemWriteEnable); end
    reset = 1'b0;
    #1;
    checks++; if (MemWriteEnable !== 1'b0) begin errors++; $display("FAIL rst_mid_we_gated got=%b want=0", MemWriteEnable); end
    @(posedge clk); #1;
    reset = 1'b1;
    checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got=rdy%b/rv%b want=rdy1/rv0", bus.req_ready, bus.resp_valid); end
    checks++; if (mem[4] !== 32'h1234BEEF || wr_count != w0) begin errors++; $display("FAIL rst_mid_mem got=%h/w%0d want=1234beef/w0", mem[4], wr_count - w0); end
    @(posedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_resp got=%b want=0", bus.resp_valid); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D, lat, rd, er);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    bus.req_addr = 32'h14;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_read got=%b want=0", bus.req_ready); end
    @(posedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h1234BEEF || bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_resp1 got=rv%b/%h/rdy%b want=rv1/1234beef/rdy0", bus.resp_valid, bus.resp_rdata, bus.req_ready); end
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=rdy%b/rv%b want=rdy1/rv0", bus.req_ready, bus.resp_valid); end
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b0 || MemAddr !== 32'h14) begin errors++; $display("FAIL b2b_accept2 got=rdy%b/%h want=rdy0/00000014", bus.req_ready, MemAddr); end
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_resp2 got=rv%b/%h want=rv1/cafef00d", bus.resp_valid, bus.resp_rdata); end
    @(posedge clk); #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the datapath's memory-stage control and DataMemory.
- Converts byte, halfword and word load/store requests into DataMemory's word-wide interface.
- Sub-word stores use read-modify-write; loads are extracted from the word and sign- or zero-extended.
- Misaligned and illegal accesses are trapped before any memory access, and results go back on a single-cycle response pulse.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and MemAddr.
- DATA_WIDTH, 32, data word width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next rising clk edge)
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data; sub-word data is right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  valid with resp_valid: misaligned access or size 11
- MemAddr  out  ADDR_WIDTH  word-aligned address to DataMemory
- MemWriteData  out  32  merged write word
- MemWriteEnable  out  1  DataMemory write strobe; commits at rising edge
- MemReadEnable  out  1  DataMemory read strobe
- MemReadData  in  32  DataMemory read data; combinational, valid in the same cycle as MemAddr/MemReadEnable

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. Reset value is IDLE.
- Reset values of registered outputs: resp_valid=0, resp_rdata=0, resp_error=0.
- Accept:
  - A request is accepted on the rising edge where req_valid && req_ready.
  - addr, size, signed, write and wdata are latched at acceptance; request inputs are ignored afterwards.
- Error check at accept:
  - Error when size==11, half with addr[0]==1, or word with addr[1:0]!=0.
  - On error: IDLE->RESP with resp_error=1. No MemReadEnable or MemWriteEnable is asserted.
- Transitions from IDLE:
  - Load: IDLE->READ->RESP. In READ, MemReadData is captured at the edge.
  - Word store: IDLE->WRITE->RESP.
  - Sub-word store: IDLE->READ->WRITE->RESP. The word read in READ is merged with the store data in WRITE.
- Latency from the accept edge to resp_valid high:
  - error: 1 cycle
  - load and word store: 2 cycles
  - sub-word store: 3 cycles
- RESP lasts exactly one cycle, then goes to IDLE. No back-pressure on the response.
- Memory-side outputs, decoded from state:
  - MemAddr = {addr[ADDR_WIDTH-1:2],2'b00} in READ and WRITE; 0 otherwise.
  - MemReadEnable=1 only in READ.
  - MemWriteEnable=1 only in WRITE, for exactly one cycle per store.
  - MemWriteData is the merged word in WRITE; 0 otherwise.
- Byte lanes are little-endian:
  - byte k=addr[1:0] occupies bits [8k+7:8k]
  - half j=addr[1] occupies bits [16j+15:16j]
- Merge replaces only the addressed lane(s) with req_wdata[7:0] or req_wdata[15:0]; all other lanes keep the read value.
- Load extension: the extracted lane is sign-extended when signed=1, otherwise zero-extended. Word loads pass through unchanged.
- resp_rdata and resp_error are updated on entry to RESP and hold their values until the next RESP.
- Reset mid-operation:
  - While reset==0, MemWriteEnable and MemReadEnable are forced to 0 combinationally, so no write commits at the reset edge.
  - The state returns to IDLE, resp_valid=0, and the in-flight request is dropped with no response.
- req_ready=0 from the accept edge until the unit re-enters IDLE. A request can never be accepted in the same cycle as its predecessor's response.

Test Plan:
1. Word store addr 0x10, wdata 0xDEADBEEF; then word load 0x10 -> one MemWriteEnable pulse with MemAddr=0x10; load resp_rdata=0xDEADBEEF, resp_error=0; resp_valid 2 cycles after each accept.
2. With mem[0x10]=0xDEADBEEF, byte store addr 0x13, wdata 0x000000AA -> one READ cycle then WRITE with MemWriteData=0xAAADBEEF; resp 3 cycles after accept. Then signed byte load 0x13 -> 0xFFFFFFAA; unsigned byte load 0x13 -> 0x000000AA.
3. With mem[0x10]=0xDEADBEEF, half store addr 0x12, wdata 0x1234 -> mem word 0x1234BEEF. Signed half load 0x10 -> 0xFFFFBEEF; unsigned half load 0x12 -> 0x00001234.
4. Word load addr 0x11; then half store addr 0x13; then load with size 11 -> each gives resp_error=1 and resp_rdata=0, 1 cycle after accept; MemReadEnable and MemWriteEnable stay 0 throughout.
5. Sub-word store in progress, reset=0 asserted during the WRITE cycle -> MemWriteEnable=0 that cycle and the memory word is unchanged. Next cycle: state IDLE, req_ready=1, resp_valid=0.
6. req_valid held high with two consecutive word loads (0x10, then 0x14) -> second request accepted only after the first RESP. req_ready is low for 2 cycles between accepts, and the responses arrive in order.
